// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder
package dmem_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam logic [31:0] DMEM_BASE = 32'h1001_0000;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM, synchronous write, registered read, no reset
module dmem_array import dmem_pkg::*; #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  // write on stores and capture the addressed word on the same edge
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with programmable wait cycles; DMEM_ERRCHK_EN enables alignment/range faults
module dmem_responder import dmem_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = DMEM_BASE,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic we_q, err_q, acc, fault;
  logic [31:0] off, ram_rdata;
  assign off = req_addr - BASE_ADDR;
  assign acc = req_valid && req_ready;
`ifdef DMEM_ERRCHK_EN
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);
  assign fault = (req_addr[1:0] != 2'b00) || (off >= SPAN);
`else
  logic unused_bits;
  assign fault = 1'b0;
  assign unused_bits = ^{off[31:AW+2], off[1:0]};
`endif
  dmem_array #(.DEPTH(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .en    (acc && !fault),
    .we    (req_we),
    .addr  (off[AW+1:2]),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );
  // next state: accept in IDLE, count down in WAIT, hold RESP until taken
  always_comb
    state_nxt = state == IDLE ? (acc ? (LATENCY == 0 ? RESP : WAIT) : IDLE)
              : state == WAIT ? (cnt == 4'd0 ? RESP : WAIT)
              : (rsp_ready ? IDLE : RESP);
  // state, latency counter and per-request attributes captured at acceptance
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      we_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        we_q <= req_we;
        err_q <= fault;
        cnt <= CNT_LOAD;
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  assign req_ready = rst && state == IDLE;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  assign rsp_err = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ram_rdata : 32'h0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed test of dmem_responder at LATENCY 2 (inst 0) and LATENCY 0 (inst 1)
module tb_dmem_responder;
`ifdef DMEM_ERRCHK_EN
  localparam bit EC = 1'b1;
`else
  localparam bit EC = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid [2];
  logic req_ready [2];
  logic req_we [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic rsp_valid [2];
  logic rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic rsp_err [2];
  logic busy [2];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  dmem_responder #(.LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );
  dmem_responder #(.LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic xact(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int n);
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k] = we;
    req_addr[k] = addr;
    req_wdata[k] = wd;
    rsp_ready[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid[k] = 1'b0;
    req_addr[k] = 32'h0;
    req_wdata[k] = 32'hFFFF_FFFF;
    n = 1;
    while (!rsp_valid[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    rd = rsp_rdata[k];
    er = rsp_err[k];
  endtask
  task automatic acc(input string tag, input int k, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic er;
    int n;
    xact(k, we, addr, wd, rd, er, n);
    chk({tag, "_lat"}, 32'(n), k == 0 ? 32'd3 : 32'd1);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int n, cnt;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_we[i] = 1'b0;
      req_addr[i] = 32'h0;
      req_wdata[i] = 32'h0;
      rsp_ready[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready[0]}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("rst_rdata", rsp_rdata[0], 32'd0);
    chk("rst_err", {31'd0, rsp_err[0]}, 32'd0);
    chk("rst_busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_req_ready0", {31'd0, req_ready[1]}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready[0]}, 32'd1);
    acc("st_beef", 0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0, 1'b0);
    acc("ld_beef", 0, 1'b0, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 1'b0);
    acc("st_w0", 0, 1'b1, 32'h1001_0000, 32'h1111_1111, 32'h0, 1'b0);
    acc("ld_w0", 0, 1'b0, 32'h1001_0000, 32'h0, 32'h1111_1111, 1'b0);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0] = 1'b0;
    req_addr[0] = 32'h1001_0004;
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    req_we[0] = 1'b1;
    req_wdata[0] = 32'hBAD0_BAD0;
    n = 1;
    while (!rsp_valid[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hold_lat", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, rsp_valid[0]}, 32'd1);
      chk("hold_rdata", rsp_rdata[0], 32'hDEAD_BEEF);
      chk("hold_err", {31'd0, rsp_err[0]}, 32'd0);
      chk("hold_req_ready", {31'd0, req_ready[0]}, 32'd0);
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("hold_release_busy", {31'd0, busy[0]}, 32'd0);
    acc("ld_after_hold", 0, 1'b0, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 1'b0);
    acc("st_alias", 0, 1'b1, 32'h1001_1000, 32'hCAFE_F00D, 32'h0, EC);
    acc("ld_w0_alias", 0, 1'b0, 32'h1001_0000, 32'h0, EC ? 32'h1111_1111 : 32'hCAFE_F00D, 1'b0);
    acc("ld_oob", 0, 1'b0, 32'h1001_1000, 32'h0, EC ? 32'h0 : 32'hCAFE_F00D, EC);
    acc("st_misalign", 0, 1'b1, 32'h1001_0006, 32'h1234_5678, 32'h0, EC);
    acc("ld_w1_misalign", 0, 1'b0, 32'h1001_0004, 32'h0, EC ? 32'hDEAD_BEEF : 32'h1234_5678, 1'b0);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0] = 1'b1;
    req_addr[0] = 32'h1001_000C;
    req_wdata[0] = 32'h0BAD_CAFE;
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("wait_busy", {31'd0, busy[0]}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_mid_valid", {31'd0, rsp_valid[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {31'd0, req_ready[0]}, 32'd1);
    acc("ld_after_rst", 0, 1'b0, 32'h1001_000C, 32'h0, 32'h0BAD_CAFE, 1'b0);
    acc("l0_st", 1, 1'b1, 32'h1001_0010, 32'h5A5A_5A5A, 32'h0, 1'b0);
    acc("l0_ld", 1, 1'b0, 32'h1001_0010, 32'h0, 32'h5A5A_5A5A, 1'b0);
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1] = 1'b0;
    req_addr[1] = 32'h1001_0010;
    rsp_ready[1] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (req_ready[1]) cnt++;
      else chk("b2b_rdata", rsp_rdata[1], 32'h5A5A_5A5A);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    chk("b2b_accepts", 32'(cnt), 32'd4);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core: the memory-side end of the load/store port the datapath drives (address = ALU result, write data = rs2, read data returned for write-back). It accepts one word request at a time over a valid/ready handshake, services it from an internal word array after a programmable number of wait cycles, and returns read data and an error flag over a second valid/ready handshake. It sits between the load/store control logic and the data address space that starts at the data segment base.

## Interface
- BASE_ADDR, 32'h1001_0000, byte address of word 0 of the array
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥ 4
- LATENCY, 2, wait cycles inserted between acceptance and response; 0 to 15
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store word, 0 = load word
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester takes the response
- rsp_rdata  out  32  load data; 0 for stores and errored accesses
- rsp_err  out  1  access faulted (see Configuration)
- busy  out  1  request in flight (state ≠ IDLE)

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: req_ready = 1. On req_valid && req_ready (acceptance edge): latch req_we, word index, error flag; for a non-faulting store, write req_wdata to the array on this edge; for a non-faulting load, read the indexed word into the response register on this edge. Go to WAIT if LATENCY > 0 (counter loaded with LATENCY−1), else RESP.
- WAIT: counter decrements each cycle; at 0 go to RESP. req_ready = 0.
- RESP: rsp_valid = 1; rsp_rdata/rsp_err stable until handshake. On rsp_ready go to IDLE. req_ready = 0.
- Word index = (req_addr − BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits (modulo subtraction, 32-bit).
- Load after store to the same word returns the stored value (store committed before any later acceptance).
- req_wdata/req_addr are sampled only on the acceptance edge; changes at other times are ignored.
- Array contents are not reset; all other state is.

## Timing
- Reset values: req_ready 0 while rst low; 1 from the first cycle after release. rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0.
- Acceptance at edge T → rsp_valid high from cycle T+1+LATENCY.
- Response held while rsp_ready = 0, with no upper bound.
- Handshake at edge R → IDLE; req_ready high in cycle R+1. Best case: one access per LATENCY+2 cycles.
- Reset asserted mid-transaction: FSM returns to IDLE immediately and the pending response is dropped. A store already accepted remains written.
- rsp_ready high while rsp_valid is low: ignored.

## Configuration
- DMEM_ERRCHK_EN defined: an access faults if req_addr[1:0] ≠ 0 or req_addr is outside [BASE_ADDR, BASE_ADDR + 4·DEPTH_WORDS). A faulting access gives rsp_err = 1 and rsp_rdata = 0; a faulting store is suppressed (array unchanged). Timing is unchanged.
- Not defined: no checks. rsp_err is tied to 0, address bits [1:0] are ignored, and out-of-range addresses wrap modulo the array size.

## Structure
- Package dmem_pkg holds:
  - the state enum typedef (IDLE/WAIT/RESP)
  - the default BASE_ADDR constant
  - the word/byte width constants
- Sub-module dmem_array:
  - single-port word RAM
  - synchronous write
  - synchronous read registered on the same edge
  - no reset
- dmem_responder holds the FSM, the latency counter, address decode and error logic.

## Test plan
- Reset then store 0xDEADBEEF to 0x10010004 with LATENCY = 2: accepted at T, rsp_valid at T+3, rsp_err 0, rsp_rdata 0. Then load 0x10010004 returns 0xDEADBEEF.
- LATENCY = 0: load accepted at T gives rsp_valid at T+1. Back-to-back loads with rsp_ready tied high are accepted every 2 cycles.
- rsp_ready held low for 5 cycles: rsp_valid, rsp_rdata and rsp_err stay stable, req_ready stays 0, and a second req_valid is not accepted.
- With DMEM_ERRCHK_EN: store to 0x10010002 or 0x10011000 (DEPTH = 1024) gives rsp_err = 1, and a subsequent load of the target word shows it unchanged. Without the macro: 0x10011000 aliases word 0.
- Reset asserted during WAIT: busy and rsp_valid drop to 0 within the same cycle, req_ready is 1 one cycle after release, and a store accepted before the reset is readable afterwards.
